fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16: width of every PC/address port.
REQ-002 SHALL have parameter RESET_PC, default 0: first fetch byte address after reset.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1: instruction-memory read strobe.
REQ-006 SHALL have port imem_addr, output, ADDRESS_BITS: byte address of the read, valid while imem_req=1.
REQ-007 SHALL have port imem_rdata, input, 32: read data, valid exactly 1 cycle after the imem_req cycle.
REQ-008 SHALL have port next_PC_select, input, 1: redirect request from decode.
REQ-009 SHALL have port target_PC, input, ADDRESS_BITS: redirect address from decode.
REQ-010 SHALL have port inst_ready, input, 1: decode accepts the presented instruction.
REQ-011 SHALL have port inst_valid, output, 1: instruction/PC outputs hold a fetched entry.
REQ-012 SHALL have port instruction, output, 32: head instruction; NOP (32'h00000013) when inst_valid=0.
REQ-013 SHALL have port PC, output, ADDRESS_BITS: byte address of the head instruction; 0 when inst_valid=0.

Function
REQ-014 SHALL keep fetch_pc; each issued request uses imem_addr=fetch_pc, then fetch_pc += 4, modulo 2^ADDRESS_BITS (0xFFFC wraps to 0x0000).
REQ-015 SHALL buffer fetched {PC, instruction} pairs in a 2-entry FIFO; head drives instruction/PC.
REQ-016 SHALL count occupancy = FIFO entries + in-flight request (0/1); imem_req=1 only when occupancy minus this cycle's pop < 2 and state is RUN.
REQ-017 SHALL pop the head on inst_valid && inst_ready; pop and push in the same cycle are allowed when full-with-pop.
REQ-018 SHALL push imem_rdata with its request address on the cycle after each non-discarded request.
REQ-019 SHALL act on redirect only when next_PC_select && inst_valid && inst_ready (decode consuming a control-transfer); next_PC_select otherwise ignored.
REQ-020 SHALL, on an accepted redirect: pop the head, flush remaining entries, mark any in-flight response discarded, set fetch_pc = {target_PC[ADDRESS_BITS-1:2], 2'b00}, issue no request that cycle.
REQ-021 SHALL have FSM states: BOOT (one cycle after reset, no request) -> RUN; RUN -> FLUSH on accepted redirect; FLUSH -> RUN after one cycle (discard slot for in-flight data).
REQ-022 SHALL never push a discarded response; first instruction after redirect reaches inst_valid 2 cycles after the redirect cycle at the earliest.
REQ-023 SHALL give steady-state throughput of 1 instruction/cycle with inst_ready held 1; minimum latency request->inst_valid = 1 cycle.
REQ-024 SHALL hold instruction/PC stable while inst_valid=1 and inst_ready=0.
REQ-025 SHALL never exceed 2 entries; an imem response with no free slot is a design error (assertion).

Reset
REQ-026 SHALL, with reset=0 at a clock edge: state=BOOT, fetch_pc=RESET_PC, FIFO empty, in-flight cleared, discard flag cleared.
REQ-027 SHALL drive during/after reset: imem_req=0, inst_valid=0, instruction=NOP, PC=0; imem_addr=RESET_PC.
REQ-028 SHALL discard any request in flight when reset asserts mid-operation; its data is never pushed.

Structure
REQ-029 SHALL place NOP encoding, FSM state encodings and the instruction width (32) in a shared package also used by decode.
REQ-030 SHALL implement the 2-entry FIFO as sub-module fetch_fifo (push/pop/flush, full/empty, count).

Verification
REQ-031 Reset release, RESET_PC=0, inst_ready=1, memory returns word=address -> imem_addr 0,4,8,... from cycle 2; inst_valid at cycle 3 with PC=0, one instruction/cycle thereafter.
REQ-032 inst_ready=0 for 5 cycles -> at most 2 entries buffered, imem_req drops, instruction/PC held; ready=1 -> PCs continue with no gap or duplicate.
REQ-033 Head PC=0x0114 is jal, next_PC_select=1, target_PC=0x0128 -> flush; next inst_valid shows PC=0x0128; no word from 0x0118/0x011C ever presented.
REQ-034 Redirect to target_PC=0x0157 -> fetch from 0x0154; and fetch_pc=0xFFFC -> next request address 0x0000.
REQ-035 next_PC_select=1 with inst_valid=0 or inst_ready=0 -> ignored, sequential fetch continues.
REQ-036 reset=0 for one cycle with request in flight -> inst_valid=0 next cycle, its data never appears, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: instruction width, NOP encoding,
// front-end FSM states and instruction buffer depth.
package fetch_unit_pkg;

    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {PC, instruction} pairs between
// the memory response and decode.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    // A full buffer may still accept a push when the head leaves this cycle.
    always_comb begin
        full      = (count_q == 2'(FIFO_DEPTH));
        empty     = (count_q == 2'd0);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        head_data = slots[rd_ptr];
        count     = count_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one outstanding
// memory read, a two-entry buffer and redirect handling for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0]   imem_rdata,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    inst_ready,
    output logic                    inst_valid,
    output logic [INST_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] PC
);

    localparam int ENTRY_BITS = ADDRESS_BITS + INST_WIDTH;

    fetch_state_e            state_q;
    fetch_state_e            state_d;
    logic [ADDRESS_BITS-1:0] fetch_pc_q;
    logic [ADDRESS_BITS-1:0] in_flight_addr_q;
    logic                    in_flight_q;
    logic                    discard_q;

    logic                    resp_valid;
    logic                    head_present;
    logic                    pop;
    logic                    redirect;
    logic                    bypass_pop;
    logic                    fifo_pop;
    logic                    fifo_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;
    logic [2:0]              occupancy;
    logic [ENTRY_BITS-1:0]   fifo_head;
    logic [ENTRY_BITS-1:0]   head_entry;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = redirect ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // When the buffer is empty the arriving response is presented directly,
    // giving one-cycle request-to-valid latency; it is only buffered if
    // decode does not take it.
    always_comb begin
        resp_valid   = in_flight_q && !discard_q;
        head_present = reset && (!fifo_empty || resp_valid);
        head_entry   = fifo_empty ? {in_flight_addr_q, imem_rdata} : fifo_head;
        inst_valid   = head_present;
        instruction  = head_present ? head_entry[INST_WIDTH-1:0] : NOP_INST;
        PC           = head_present ? head_entry[ENTRY_BITS-1:INST_WIDTH] : '0;
        pop          = head_present && inst_ready;
        redirect     = pop && next_PC_select;
        bypass_pop   = pop && fifo_empty;
        fifo_pop     = pop && !fifo_empty;
        fifo_push    = reset && resp_valid && !bypass_pop && !redirect;
        occupancy    = {1'b0, fifo_count} + {2'b00, in_flight_q};
        imem_req     = reset && (state_q == RUN) && !redirect
                       && (occupancy < (3'd2 + {2'b00, pop}));
        imem_addr    = fetch_pc_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q       <= RESET_PC;
            in_flight_q      <= 1'b0;
            in_flight_addr_q <= RESET_PC;
            discard_q        <= 1'b0;
        end else begin
            in_flight_q <= imem_req;
            discard_q   <= redirect;
            if (imem_req) begin
                in_flight_addr_q <= fetch_pc_q;
            end
            if (redirect) begin
                fetch_pc_q <= target_PC & ~ADDRESS_BITS'(3);
            end else if (imem_req) begin
                fetch_pc_q <= fetch_pc_q + ADDRESS_BITS'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect),
        .push_data ({in_flight_addr_q, imem_rdata}),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A response must always find a free slot; the request throttle guarantees it.
    assert property (@(posedge clock) disable iff (!reset)
                     !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected fetch
// addresses and presented {PC, instruction} pairs against a word=address memory.
module tb_fetch_unit;

    localparam int          AB  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AB-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          next_PC_select = 1'b0;
    logic [AB-1:0] target_PC = '0;
    logic          inst_ready = 1'b0;
    logic          inst_valid;
    logic [31:0]   instruction;
    logic [AB-1:0] PC;

    int            checks = 0;
    int            errors = 0;
    logic [AB-1:0] exp_q[$];
    logic [AB-1:0] exp_next_pc;
    logic [AB-1:0] exp_req_addr;
    int            outstanding;
    logic          last_valid;

    always #5 clock = ~clock;

    fetch_unit #(
        .ADDRESS_BITS (AB),
        .RESET_PC     (16'h0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .next_PC_select (next_PC_select),
        .target_PC      (target_PC),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .PC             (PC)
    );

    function automatic logic [31:0] memWord(input logic [AB-1:0] a);
        return 32'(a);
    endfunction

    // Memory answers one cycle after the request; unrequested cycles carry poison.
    always @(posedge clock) begin
        imem_rdata <= imem_req ? memWord(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(exp_next_pc);
            exp_next_pc += AB'(4);
        end
    endtask

    task automatic modelRestart(input logic [AB-1:0] start);
        exp_q.delete();
        exp_next_pc  = start;
        exp_req_addr = start;
        outstanding  = 0;
        refill();
    endtask

    task automatic sampleCycle();
        #1;
        if (!reset) begin
            checkOutput("rst_req", 32'(imem_req), 32'd0);
            checkOutput("rst_valid", 32'(inst_valid), 32'd0);
            checkOutput("rst_pc", 32'(PC), 32'd0);
            checkOutput("rst_inst", instruction, NOP);
            modelRestart(16'h0000);
            last_valid = 1'b0;
            return;
        end
        last_valid = inst_valid;
        if (imem_req) begin
            checkOutput("req_addr", 32'(imem_addr), 32'(exp_req_addr));
            exp_req_addr += AB'(4);
            outstanding++;
        end
        if (inst_valid) begin
            checkOutput("head_pc", 32'(PC), 32'(exp_q[0]));
            checkOutput("head_inst", instruction, memWord(exp_q[0]));
            if (inst_ready) begin
                void'(exp_q.pop_front());
                outstanding--;
                if (next_PC_select) begin
                    checkOutput("redir_no_req", 32'(imem_req), 32'd0);
                    modelRestart(target_PC & ~AB'(3));
                end
                refill();
            end
        end else begin
            checkOutput("idle_pc", 32'(PC), 32'd0);
            checkOutput("idle_inst", instruction, NOP);
        end
        checkOutput("occupancy_le2", 32'(outstanding <= 2), 32'd1);
    endtask

    task automatic applyStimulus(input logic rdy, input logic sel, input logic [AB-1:0] tgt);
        @(negedge clock);
        reset          = 1'b1;
        inst_ready     = rdy;
        next_PC_select = sel;
        target_PC      = tgt;
        sampleCycle();
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            reset          = 1'b0;
            inst_ready     = 1'b1;
            next_PC_select = 1'b0;
            sampleCycle();
        end
    endtask

    // Waits for the head to reach at_pc, redirects there, then measures how
    // long the first target instruction takes to appear.
    task automatic applyRedirectAt(input logic [AB-1:0] at_pc, input logic [AB-1:0] tgt);
        logic hit = 1'b0;
        int   lat = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clock);
            reset          = 1'b1;
            hit            = inst_valid && (PC == at_pc);
            inst_ready     = 1'b1;
            next_PC_select = hit;
            target_PC      = tgt;
            sampleCycle();
        end
        checkOutput("redir_hit", 32'(hit), 32'd1);
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            applyStimulus(1'b1, (n == 1), 16'h0888);
            if (last_valid) lat = n;
        end
        checkOutput("redir_seen", 32'(lat != 0), 32'd1);
        checkOutput("redir_latency_ge2", 32'(lat >= 2), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelRestart(16'h0000);
        last_valid = 1'b0;
        doReset(2);

        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("boot_no_req", 32'(imem_req), 32'd0);
        checkOutput("boot_addr", 32'(imem_addr), 32'h0000);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("c2_req", 32'(imem_req), 32'd1);
        checkOutput("c2_valid", 32'(inst_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("c3_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("throughput", 32'(inst_valid), 32'd1);
        end

        // Decode stalls with a stray select that must be ignored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0888);
            checkOutput("stall_valid", 32'(inst_valid), 32'd1);
        end
        checkOutput("stall_req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("resume_valid", 32'(inst_valid), 32'd1);
        end

        applyRedirectAt(16'h0114, 16'h0128);
        applyRedirectAt(16'h0140, 16'h0157);
        applyRedirectAt(16'h0170, 16'hFFF3);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
        end

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), AB'($urandom));
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("pre_rst_req", 32'(imem_req), 32'd1);
        doReset(1);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("post_rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("post_rst_addr", 32'(imem_addr), 32'h0000);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
